comb_vector_sequencer: RTL and testbench



---
 rtl/comb_vector_sequencer.sv | 134 +++++++++++++
 tb/tb_comb_vector_sequencer.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/comb_vector_sequencer.sv
// Clocked stimulus/response sequencer for a small combinational block under test.
// Drives each stored vector onto X, waits SETTLE cycles, then checks F against the stored expectation.
module comb_vector_sequencer #(
  parameter int VEC_W  = 3,
  parameter int DEPTH  = 8,
  parameter int SETTLE = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       load_en,
  input  logic [$clog2(DEPTH)-1:0]   load_addr,
  input  logic [VEC_W-1:0]           load_vec,
  input  logic                       load_exp,
  input  logic                       start,
  output logic [VEC_W-1:0]           X,
  input  logic                       F,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(DEPTH+1)-1:0] err_count,
  output logic                       err_flag,
  output logic [$clog2(DEPTH)-1:0]   first_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(SETTLE + 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [SW-1:0]     cnt_q, cnt_d;
  logic [VEC_W-1:0]  x_q, x_d;
  logic [CW-1:0]     err_cnt_q, err_cnt_d;
  logic              err_flag_q, err_flag_d;
  logic [AW-1:0]     first_err_q, first_err_d;

  // Table has no reset: contents are undefined until loaded.
  logic [VEC_W-1:0]  vec_mem [DEPTH];
  logic [DEPTH-1:0]  exp_mem;

  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && load_en) begin
      vec_mem[load_addr] <= load_vec;
      exp_mem[load_addr] <= load_exp;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      x_q         <= '0;
      err_cnt_q   <= '0;
      err_flag_q  <= 1'b0;
      first_err_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      x_q         <= x_d;
      err_cnt_q   <= err_cnt_d;
      err_flag_q  <= err_flag_d;
      first_err_q <= first_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    x_d         = x_q;
    err_cnt_d   = err_cnt_q;
    err_flag_d  = err_flag_q;
    first_err_d = first_err_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_APPLY;
          idx_d       = '0;
          err_cnt_d   = '0;
          err_flag_d  = 1'b0;
          first_err_d = '0;
        end
      end
      S_APPLY: begin
        x_d   = vec_mem[idx_q];
        cnt_d = '0;
        if (SETTLE > 0) state_d = S_SETTLE;
        else            state_d = S_SAMPLE;
      end
      S_SETTLE: begin
        if (cnt_q == SW'(SETTLE - 1)) state_d = S_SAMPLE;
        else                          cnt_d   = cnt_q + SW'(1);
      end
      S_SAMPLE: begin
        // At most DEPTH mismatches per run, so the counter cannot wrap.
        if (F != exp_mem[idx_q]) begin
          err_cnt_d = err_cnt_q + CW'(1);
          if (!err_flag_q) begin
            first_err_d = idx_q;
            err_flag_d  = 1'b1;
          end
        end
        if (idx_q == AW'(DEPTH - 1)) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + AW'(1);
          state_d = S_APPLY;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign X         = x_q;
  assign busy      = (state_q == S_APPLY) || (state_q == S_SETTLE) || (state_q == S_SAMPLE);
  assign done      = (state_q == S_DONE);
  assign err_count = err_cnt_q;
  assign err_flag  = err_flag_q;
  assign first_err = first_err_q;

endmodule

// File: tb/tb_comb_vector_sequencer.sv
// Directed bench for comb_vector_sequencer; the block under test is a 3-input majority gate.
module tb_comb_vector_sequencer;

  logic       clk;
  logic       rst_n;
  logic       load_en;
  logic [2:0] load_addr;
  logic [2:0] load_vec;
  logic       load_exp;
  logic       start;
  logic [2:0] X;
  logic       F;
  logic       busy;
  logic       done;
  logic [3:0] err_count;
  logic       err_flag;
  logic [2:0] first_err;

  int n_cmp;
  int n_err;

  comb_vector_sequencer #(.VEC_W(3), .DEPTH(8), .SETTLE(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_vec  (load_vec),
    .load_exp  (load_exp),
    .start     (start),
    .X         (X),
    .F         (F),
    .busy      (busy),
    .done      (done),
    .err_count (err_count),
    .err_flag  (err_flag),
    .first_err (first_err)
  );

  function automatic logic maj(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

  assign F = maj(X);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_X"},         32'(X), 0);
    check({tag, "_busy"},      32'(busy), 0);
    check({tag, "_done"},      32'(done), 0);
    check({tag, "_err_count"}, 32'(err_count), 0);
    check({tag, "_err_flag"},  32'(err_flag), 0);
    check({tag, "_first_err"}, 32'(first_err), 0);
  endtask

  // bad_mask selects entries whose expected value is inverted.
  task automatic load_table(input logic [7:0] bad_mask);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      load_en   = 1'b1;
      load_addr = 3'(i);
      load_vec  = 3'(i);
      load_exp  = maj(3'(i)) ^ bad_mask[i];
    end
    @(posedge clk); #1;
    load_en = 1'b0;
  endtask

  task automatic run_check(input string tag, input bit with_load, input logic lexp,
                           input bit disturb, input int e_cnt, input int e_flag, input int e_first);
    int done_seen;
    done_seen = 0;
    @(posedge clk); #1;
    start = 1'b1;
    if (with_load) begin
      load_en = 1'b1; load_addr = 3'd0; load_vec = 3'd0; load_exp = lexp;
    end
    @(posedge clk); #1;
    start = 1'b0; load_en = 1'b0;
    check({tag, "_busy_t1"}, 32'(busy), 1);
    for (int k = 1; k <= 35; k++) begin
      @(posedge clk); #1;
      start = 1'b0; load_en = 1'b0;
      check({tag, "_X"},    32'(X), (k <= 32) ? (k - 1) / 4 : 7);
      check({tag, "_done"}, 32'(done), 32'(k == 32));
      check({tag, "_busy"}, 32'(busy), 32'(k < 32));
      if (done) done_seen++;
      if (disturb && (k == 10 || k == 20 || k == 31 || k == 32)) begin
        start = 1'b1; load_en = 1'b1; load_addr = 3'd0; load_vec = 3'd5; load_exp = 1'b1;
      end
    end
    check({tag, "_done_count"}, 32'(done_seen), 1);
    check({tag, "_err_count"},  32'(err_count), 32'(e_cnt));
    check({tag, "_err_flag"},   32'(err_flag), 32'(e_flag));
    check({tag, "_first_err"},  32'(first_err), 32'(e_first));
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n     = 1'b0;
    start     = 1'b1;
    load_en   = 1'b1;
    load_addr = 3'd3;
    load_vec  = 3'd7;
    load_exp  = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    start = 1'b0; load_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check_outputs_zero("idle");

    load_table(8'h00);
    run_check("clean", 1'b0, 1'b0, 1'b0, 0, 0, 0);

    load_table(8'h48);
    run_check("errors", 1'b0, 1'b0, 1'b0, 2, 1, 3);

    // Reset in the middle of vector 4 of an erroring run.
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (18) @(posedge clk);
    #1;
    check("midrst_pre_X",   32'(X), 4);
    check("midrst_pre_cnt", 32'(err_count), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;

    load_table(8'h00);
    run_check("after_rst", 1'b0, 1'b0, 1'b0, 0, 0, 0);

    run_check("blocking", 1'b0, 1'b0, 1'b1, 0, 0, 0);
    run_check("unchanged", 1'b0, 1'b0, 1'b0, 0, 0, 0);

    run_check("load_start", 1'b1, ~maj(3'd0), 1'b0, 1, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
